// File: rtl/plab2_proc_mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
package plab2_proc_mul_arbiter_pkg;

   // Muldiv request message: {func[2:0], a[31:0], b[31:0]}
   localparam int unsigned PLAB1_IMUL_MULDIV_REQ_MSG_NBITS = 3 + 32 + 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/plab2_proc_mul_arbiter_rrgrant2.sv
// Two-input round-robin picker used by the multiplier arbiter.
module plab2_proc_RRGrant2
   import plab2_proc_mul_arbiter_pkg::*;
(
   input  logic [1:0] vals,
   input  logic       last_grant,
   output logic       grant,
   output logic       any
);

   // A lone valid requester wins; on contention the one not served last wins.
   always_comb begin
      any   = |vals;
      grant = last_grant;
      case (vals)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = last_grant;
      endcase
   end

endmodule

// File: rtl/plab2_proc_mul_arbiter.sv
// Shares one variable-latency multiplier between two requesters, one
// transaction in flight, with round-robin or fixed time-division issue.
module plab2_proc_mul_arbiter
   import plab2_proc_mul_arbiter_pkg::*;
#(
   parameter int unsigned p_req_nbits   = PLAB1_IMUL_MULDIV_REQ_MSG_NBITS,
   parameter int unsigned p_resp_nbits  = 32,
   parameter bit          p_tdm         = 1'b0,
   parameter int unsigned p_slot_cycles = 40
)(
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    req0_val,
   output logic                    req0_rdy,
   input  logic [p_req_nbits-1:0]  req0_msg,
   input  logic                    req0_domain,

   input  logic                    req1_val,
   output logic                    req1_rdy,
   input  logic [p_req_nbits-1:0]  req1_msg,
   input  logic                    req1_domain,

   output logic                    resp0_val,
   input  logic                    resp0_rdy,
   output logic [p_resp_nbits-1:0] resp0_msg,

   output logic                    resp1_val,
   input  logic                    resp1_rdy,
   output logic [p_resp_nbits-1:0] resp1_msg,

   output logic                    mul_req_val,
   input  logic                    mul_req_rdy,
   output logic [p_req_nbits-1:0]  mul_req_msg,
   output logic                    mul_domain,

   input  logic                    mul_resp_val,
   output logic                    mul_resp_rdy,
   input  logic [p_resp_nbits-1:0] mul_resp_msg,

   output logic                    slot_err
);

   localparam int unsigned       SLOT_W    = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(p_slot_cycles - 1);

   arb_state_t             state, state_next;
   logic                   last_grant;
   logic                   owner;
   logic                   owner_domain;
   logic [SLOT_W-1:0]      slot_cnt;
   logic                   slot_owner;

   logic                   rr_grant;
   logic                   rr_any;
   logic                   grant;
   logic                   g_val;
   logic                   g_domain;
   logic [p_req_nbits-1:0] g_msg;
   logic                   issue_ok;
   logic                   req_fire;
   logic                   resp_fire;

   plab2_proc_RRGrant2 rr_pick (
      .vals       ({req1_val, req0_val}),
      .last_grant (last_grant),
      .grant      (rr_grant),
      .any        (rr_any)
   );

   // Select the candidate requester and whether this cycle may issue.
   always_comb begin
      grant    = p_tdm ? slot_owner : rr_grant;
      g_val    = p_tdm ? (grant ? req1_val : req0_val) : rr_any;
      g_msg    = grant ? req1_msg : req0_msg;
      g_domain = grant ? req1_domain : req0_domain;
      issue_ok = !p_tdm || (slot_cnt == '0);
   end

   // Response data fans out to both requesters; only valid is steered.
   always_comb begin
      resp0_msg = mul_resp_msg;
      resp1_msg = mul_resp_msg;
   end

   // FSM next state and handshake steering; reset forces every val/rdy low.
   always_comb begin
      state_next   = state;
      req0_rdy     = 1'b0;
      req1_rdy     = 1'b0;
      mul_req_val  = 1'b0;
      mul_req_msg  = g_msg;
      mul_domain   = g_domain;
      resp0_val    = 1'b0;
      resp1_val    = 1'b0;
      mul_resp_rdy = 1'b0;
      req_fire     = 1'b0;
      resp_fire    = 1'b0;

      unique case (state)
         ARB_IDLE: begin
            mul_req_val = g_val && issue_ok;
            if (grant) req1_rdy = mul_req_rdy && issue_ok;
            else       req0_rdy = mul_req_rdy && issue_ok;
            req_fire = mul_req_val && mul_req_rdy;
            if (req_fire) state_next = ARB_BUSY;
         end
         ARB_BUSY: begin
            mul_domain = owner_domain;
            if (owner) begin
               resp1_val    = mul_resp_val;
               mul_resp_rdy = resp1_rdy;
            end else begin
               resp0_val    = mul_resp_val;
               mul_resp_rdy = resp0_rdy;
            end
            resp_fire = mul_resp_val && mul_resp_rdy;
            if (resp_fire) state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase

      if (reset) begin
         req0_rdy     = 1'b0;
         req1_rdy     = 1'b0;
         mul_req_val  = 1'b0;
         resp0_val    = 1'b0;
         resp1_val    = 1'b0;
         mul_resp_rdy = 1'b0;
         req_fire     = 1'b0;
         resp_fire    = 1'b0;
      end
   end

   // State register plus owner capture on issue and round-robin history on completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ARB_IDLE;
         last_grant   <= 1'b1;
         owner        <= 1'b0;
         owner_domain <= 1'b0;
      end else begin
         state <= state_next;
         if (req_fire) begin
            owner        <= grant;
            owner_domain <= g_domain;
         end
         if (resp_fire) last_grant <= owner;
      end
   end

   // Free-running TDM slot counter; a transaction still in flight at slot end is flagged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt   <= '0;
         slot_owner <= 1'b0;
         slot_err   <= 1'b0;
      end else if (p_tdm) begin
         if (slot_cnt == SLOT_LAST) begin
            slot_cnt   <= '0;
            slot_owner <= ~slot_owner;
            if (state == ARB_BUSY) slot_err <= 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/plab2_proc_mul_arbiter.md
# plab2_proc_mul_arbiter

Shares one `plab1_imul_IntMulVarLat` multiplier between two requesters, such as two pipelined cores or two security domains of one core. It sits between the requesters' D-stage `mul_req` / X-stage `mul_resp` handshakes and the single multiplier instance. It allows one transaction in flight at a time and routes each response back to the requester that issued it. The default mode is round-robin. An optional time-division (TDM) mode gives each requester a fixed issue slot, so that one domain's multiplier use cannot modulate the other's latency.

## Interface
Parameters:
- p_req_nbits, default `PLAB1_IMUL_MULDIV_REQ_MSG_NBITS`: request message width.
- p_resp_nbits, default 32: response message width.
- p_tdm, default 0: 0 selects round-robin, 1 selects time-division slots.
- p_slot_cycles, default 40: TDM slot length in cycles; must be ≥ worst-case multiplier latency + 2.

Ports:
- clk, in, 1: clock. The block has one clock.
- reset, in, 1: reset, asynchronous, active-high.
- reqN_val, in, 1 (N=0,1): request valid.
- reqN_rdy, out, 1: request ready.
- reqN_msg, in, p_req_nbits: request message.
- reqN_domain, in, 1: security domain of requester N.
- respN_val, out, 1: response valid to requester N.
- respN_rdy, in, 1: response ready from requester N.
- respN_msg, out, p_resp_nbits: response message to requester N.
- mul_req_val, out, 1: request valid to the multiplier.
- mul_req_rdy, in, 1: multiplier request ready.
- mul_req_msg, out, p_req_nbits: request message to the multiplier.
- mul_domain, out, 1: domain of the current owner; drives the multiplier's `domain`.
- mul_resp_val, in, 1: multiplier response valid.
- mul_resp_rdy, out, 1: response ready to the multiplier.
- mul_resp_msg, in, p_resp_nbits: multiplier response message.
- slot_err, out, 1: sticky flag, TDM response overran its slot.

## Operation
- State machine has two states.
  - IDLE: selects a grant and passes the granted request straight through combinationally.
    - Outputs: `mul_req_val=reqG_val`, `mul_req_msg=reqG_msg`, `reqG_rdy=mul_req_rdy`; the other requester's rdy is 0.
    - On `mul_req_val && mul_req_rdy`: latch owner=G and owner_domain, then go to BUSY.
  - BUSY: all `reqN_rdy`=0 and `mul_req_val`=0.
    - Outputs: `respOwner_val=mul_resp_val`, `respOwner_msg=mul_resp_msg`, `mul_resp_rdy=respOwner_rdy`; the other resp_val is 0.
    - On the response handshake: set last_grant=owner, then go to IDLE.
- Round-robin grant (p_tdm=0):
  - If only one requester is valid, it wins.
  - If both are valid, the requester ≠ last_grant wins.
  - If neither is valid, G=last_grant and nothing issues.
- TDM grant (p_tdm=1):
  - slot_cnt counts 0..p_slot_cycles-1 and wraps; slot_owner toggles on each wrap.
  - Issue is permitted only in IDLE, with slot_cnt==0, and only for G=slot_owner. An invalid slot owner forfeits the slot.
  - If BUSY at slot_cnt==p_slot_cycles-1: set slot_err=1 and keep waiting for the response. The next slot's issue opportunity is lost, because state ≠ IDLE.
- mul_domain:
  - BUSY: owner_domain.
  - IDLE: reqG_domain.
- respN_msg is driven from mul_resp_msg for both N; only val is gated.

## Timing
- Reset (async, active-high) values:
  - state=IDLE, last_grant=1 (so req0 wins first), owner=0, owner_domain=0.
  - slot_cnt=0, slot_owner=0, slot_err=0.
  - All outputs val/rdy=0.
- The arbiter adds 0 cycles of latency on each path; request and response paths are combinational pass-through.
- Minimum back-to-back spacing: the next issue is possible in the cycle after the response handshake.
- Simultaneous requests in IDLE are resolved within the same cycle; the loser's rdy stays 0 and its val is held by protocol.
- A requester dropping val before its handshake does not issue; the grant is re-evaluated every cycle in IDLE.
- Reset mid-BUSY:
  - Returns to IDLE immediately.
  - Any in-flight multiplier response is dropped; the multiplier shares the same reset.
- TDM issue timing is independent of the other requester's behaviour. Requester N's issue cycles are always ≡ N·p_slot_cycles mod 2·p_slot_cycles.

## Structure
- Shared package / header: state encodings `ARB_IDLE=1'b0`, `ARB_BUSY=1'b1`.
  - Message widths reuse the `plab1-imul-msgs.v` macros.
- One sub-module, `plab2_proc_RRGrant2`: a 2-input round-robin picker (vals, last_grant → grant, any).
- TDM counter and FSM stay in the top module.

## Test plan
- Single request: req0 val with msg a=3, b=7 → mul_req_val same cycle; resp0_val with msg 21 when the multiplier answers; resp1_val stays 0.
- Contention: req0 and req1 both valid every cycle for 4 transactions → grant order 0,1,0,1; each response returns to the issuer.
- Backpressure: resp1_rdy=0 for 5 cycles while BUSY, owner=1 → mul_resp_rdy=0, state stays BUSY, req0_rdy=0 throughout.
- TDM, p_slot_cycles=40: req1 valid from cycle 3 → issues at cycle 40; req0 valid at cycle 41 → issues at cycle 80, regardless of req1 latency.
- Slot overrun: TDM with p_slot_cycles=10 and the multiplier stalled 15 cycles → slot_err=1 at cycle 9, stays set until reset; the response is still delivered.
- Async reset mid-BUSY: pulse reset between clock edges → all val/rdy=0 immediately; first post-reset grant goes to req0.
